// File: rtl/vram_fetch_if.sv
// Signal bundle between the tile-fetch arbiter and its video timing, VRAM, char ROM,
// pixel shifter and CPU bus.
interface vram_fetch_if #(
  parameter int unsigned AW = 10
);
  logic          pix_ce;
  logic          line_start;
  logic [7:0]    line;
  logic          vblank;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [7:0]    vram_d;
  logic [7:0]    vram_q;
  logic [10:0]   rom_addr;
  logic [7:0]    rom_q;
  logic [7:0]    pix_data;
  logic          shift_load_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic [7:0]    cpu_rdata;
  logic          cpu_wait;
  logic          cpu_ack;

  modport master (
    input  pix_ce, line_start, line, vblank, vram_q, rom_q,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vram_addr, vram_we, vram_d, rom_addr, pix_data, shift_load_n,
    output cpu_rdata, cpu_wait, cpu_ack
  );

  modport slave (
    output pix_ce, line_start, line, vblank, vram_q, rom_q,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vram_addr, vram_we, vram_d, rom_addr, pix_data, shift_load_n,
    input  cpu_rdata, cpu_wait, cpu_ack
  );
endinterface

// File: rtl/vram_fetch_arbiter.sv
// Background tile fetch sequencer (tile code, pattern byte, shifter load) sharing a
// single-port VRAM with CPU accesses that are slotted into the free fetch phases.
module vram_fetch_arbiter #(
  parameter int unsigned COLS = 32,
  parameter int unsigned AW   = 10
) (
  input logic          clk,
  input logic          n_clr,
  vram_fetch_if.master bus
);

  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {StIdle, StGrant, StAck} state_e;

  state_e          state, state_next;
  logic [2:0]      ph;
  logic [ColW-1:0] col;
  logic [7:0]      code_reg;
  logic [7:0]      pix_data;
  logic [7:0]      cpu_rdata;
  logic [AW-1:0]   video_addr;
  logic            window;

  assign video_addr = AW'({bus.line[7:3], col});
  // Phases 0-1 belong to the tile-code read; vblank frees every phase.
  assign window     = ((ph >= 3'd2) && (ph <= 3'd6)) || bus.vblank;

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      ph  <= '0;
      col <= '0;
    end else if (bus.line_start) begin
      ph  <= '0;
      col <= '0;
    end else if (bus.pix_ce) begin
      ph <= ph + 3'd1;
      if (ph == 3'd7) begin
        col <= (col == ColW'(COLS - 1)) ? '0 : col + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      code_reg  <= '0;
      pix_data  <= '0;
      cpu_rdata <= '0;
    end else begin
      if (bus.pix_ce && (ph == 3'd1) && (state != StGrant)) begin
        code_reg <= bus.vram_q;
      end
      if (bus.pix_ce && (ph == 3'd6)) begin
        pix_data <= bus.rom_q;
      end
      if ((state == StGrant) && !bus.cpu_we) begin
        cpu_rdata <= bus.vram_q;
      end
    end
  end

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      StIdle:  if (bus.cpu_req && window) state_next = StGrant;
      StGrant: state_next = StAck;
      StAck:   state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.vram_addr = video_addr;
    bus.vram_we   = 1'b0;
    bus.cpu_wait  = 1'b0;
    bus.cpu_ack   = 1'b0;
    unique case (state)
      StIdle: bus.cpu_wait = bus.cpu_req;
      StGrant: begin
        bus.vram_addr = bus.cpu_addr;
        bus.vram_we   = bus.cpu_we;
        bus.cpu_wait  = 1'b1;
      end
      StAck:   bus.cpu_ack = 1'b1;
      default: bus.cpu_wait = bus.cpu_req;
    endcase
  end

  assign bus.vram_d       = bus.cpu_wdata;
  assign bus.rom_addr     = {code_reg, bus.line[2:0]};
  assign bus.shift_load_n = (ph != 3'd7);
  assign bus.pix_data     = pix_data;
  assign bus.cpu_rdata    = cpu_rdata;

endmodule
